// File: rtl/alu_control.sv
// rtl/alu_control.sv - registered LEGv8 ALU control decoder (ALUOp + opcode -> ALUCtl)
module alu_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    input  logic [1:0]  ALUOp,
    output logic [3:0]  ALUCtl
);

    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_ORR  = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_EOR  = 4'b0011;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_PASS = 4'b0111;
    localparam logic [3:0] CTL_LSL  = 4'b1000;
    localparam logic [3:0] CTL_LSR  = 4'b1001;

    localparam logic [1:0] OP_MEM  = 2'b00;
    localparam logic [1:0] OP_CBZ  = 2'b01;
    localparam logic [1:0] OP_RTYP = 2'b10;
    localparam logic [1:0] OP_ITYP = 2'b11;

    logic [3:0] ctl_q;
    logic [3:0] ctl_d;
    logic [3:0] r_ctl;
    logic [3:0] i_ctl;

    // R-type: full 11-bit match; flag-setting forms share the plain decode.
    always_comb begin
        r_ctl = CTL_ADD;
        case (opcode)
            11'b10001011000, 11'b10101011000: r_ctl = CTL_ADD;
            11'b11001011000, 11'b11101011000: r_ctl = CTL_SUB;
            11'b10001010000, 11'b11101010000: r_ctl = CTL_AND;
            11'b10101010000:                  r_ctl = CTL_ORR;
            11'b11001010000:                  r_ctl = CTL_EOR;
            11'b11010011011:                  r_ctl = CTL_LSL;
            11'b11010011010:                  r_ctl = CTL_LSR;
            default:                          r_ctl = CTL_ADD;
        endcase
    end

    // I-type: opcode[0] is immediate payload, so only [10:1] is decoded.
    always_comb begin
        i_ctl = CTL_ADD;
        case (opcode[10:1])
            10'b1001000100, 10'b1011000100: i_ctl = CTL_ADD;
            10'b1101000100, 10'b1111000100: i_ctl = CTL_SUB;
            10'b1001001000, 10'b1111001000: i_ctl = CTL_AND;
            10'b1011001000:                 i_ctl = CTL_ORR;
            10'b1101001000:                 i_ctl = CTL_EOR;
            default:                        i_ctl = CTL_ADD;
        endcase
    end

    // ALUOp selects first so an unknown opcode cannot reach the flop for 00/01.
    always_comb begin
        ctl_d = CTL_ADD;
        case (ALUOp)
            OP_MEM:  ctl_d = CTL_ADD;
            OP_CBZ:  ctl_d = CTL_PASS;
            OP_RTYP: ctl_d = r_ctl;
            OP_ITYP: ctl_d = i_ctl;
            default: ctl_d = CTL_ADD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q <= CTL_AND;
        end else begin
            ctl_q <= ctl_d;
        end
    end

    assign ALUCtl = ctl_q;

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - self-checking bench for alu_control
module tb_alu_control;

    logic        clk;
    logic        rst;
    logic [10:0] opcode;
    logic [1:0]  ALUOp;
    logic [3:0]  ALUCtl;

    int n_cmp = 0;
    int n_bad = 0;

    alu_control dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .ALUOp  (ALUOp),
        .ALUCtl (ALUCtl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  alu_op;
        logic [10:0] opc;
        logic [3:0]  exp;
    } vec_t;

    // Instruction tables from the ISA: mnemonic opcode -> ALU operation.
    logic [10:0] r_opc [10] = '{11'b10001011000, 11'b10101011000, 11'b11001011000,
                                11'b11101011000, 11'b10001010000, 11'b11101010000,
                                11'b10101010000, 11'b11001010000, 11'b11010011011,
                                11'b11010011010};
    logic [3:0]  r_res [10] = '{4'd2, 4'd2, 4'd6, 4'd6, 4'd0, 4'd0, 4'd1, 4'd3, 4'd8, 4'd9};
    logic [9:0]  i_opc [8]  = '{10'b1001000100, 10'b1011000100, 10'b1101000100,
                                10'b1111000100, 10'b1001001000, 10'b1111001000,
                                10'b1011001000, 10'b1101001000};
    logic [3:0]  i_res [8]  = '{4'd2, 4'd2, 4'd6, 4'd6, 4'd0, 4'd0, 4'd1, 4'd3};

    function automatic logic [3:0] model(input logic [1:0] op, input logic [10:0] opc);
        logic [3:0] r;
        r = 4'd2;
        if (op == 2'd1) r = 4'd7;
        else if (op == 2'd2) begin
            foreach (r_opc[k]) if (r_opc[k] == opc) r = r_res[k];
        end else if (op == 2'd3) begin
            foreach (i_opc[k]) if (i_opc[k] == opc[10:1]) r = i_res[k];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] exp);
        n_cmp++;
        if (ALUCtl !== exp) begin
            n_bad++;
            $display("FAIL %s: ALUCtl=%b expected=%b", name, ALUCtl, exp);
        end
    endtask

    // Apply inputs just after an edge, clock one edge, sample 1ns later.
    task automatic step(input logic r, input logic [1:0] op, input logic [10:0] opc,
                        input logic [3:0] exp, input string name);
        rst = r; ALUOp = op; opcode = opc;
        @(posedge clk); #1;
        check(name, exp);
    endtask

    vec_t vecs [15];

    initial begin
        vecs[0]  = '{2'b10, 11'b10001011000, 4'b0010};
        vecs[1]  = '{2'b10, 11'b11001011000, 4'b0110};
        vecs[2]  = '{2'b10, 11'b10001010000, 4'b0000};
        vecs[3]  = '{2'b10, 11'b10101010000, 4'b0001};
        vecs[4]  = '{2'b10, 11'b11001010000, 4'b0011};
        vecs[5]  = '{2'b10, 11'b11010011011, 4'b1000};
        vecs[6]  = '{2'b10, 11'b11010011010, 4'b1001};
        vecs[7]  = '{2'b10, 11'b00000000000, 4'b0010};
        vecs[8]  = '{2'b11, 11'b11010001000, 4'b0110};
        vecs[9]  = '{2'b11, 11'b10110010001, 4'b0001};
        vecs[10] = '{2'b11, 11'b10010001001, 4'b0010};
        vecs[11] = '{2'b10, 11'b11101010000, 4'b0000};
        vecs[12] = '{2'b11, 11'b11010010000, 4'b0011};
        vecs[13] = '{2'b11, 11'b11110010001, 4'b0000};
        vecs[14] = '{2'b11, 11'b00000000001, 4'b0010};

        rst = 1'b1; ALUOp = 2'b10; opcode = 11'b11001011000;
        @(negedge clk);
        step(1'b1, 2'b10, 11'b11001011000, 4'b0000, "reset_edge1");
        step(1'b1, 2'b10, 11'b11001011000, 4'b0000, "reset_edge2");
        step(1'b0, 2'b10, 11'b11001011000, 4'b0110, "reset_release");

        step(1'b0, 2'b00, 11'bx, 4'b0010, "aluop00_xopc");
        step(1'b0, 2'b01, 11'bx, 4'b0111, "aluop01_xopc");

        for (int i = 0; i < 15; i++)
            step(1'b0, vecs[i].alu_op, vecs[i].opc, vecs[i].exp, $sformatf("vec%0d", i));

        // Mid-cycle input change must not show until the next rising edge.
        step(1'b0, 2'b10, 11'b11010011011, 4'b1000, "lat_pre");
        @(negedge clk);
        ALUOp = 2'b10; opcode = 11'b11010011010;
        #1 check("lat_hold", 4'b1000);
        @(posedge clk); #1;
        check("lat_update", 4'b1001);

        // Mid-stream reset drops the pending decode; next edge loads current inputs.
        step(1'b0, 2'b01, 11'd0, 4'b0111, "mid_pre");
        step(1'b1, 2'b10, 11'b11001010000, 4'b0000, "mid_reset");
        step(1'b0, 2'b11, 11'b11010001000, 4'b0110, "mid_resume");

        for (int i = 0; i < 400; i++) begin
            logic [1:0]  op;
            logic [10:0] opc;
            logic        r;
            int          sel;
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 3);
            if (sel == 0)      opc = r_opc[$urandom_range(0, 9)];
            else if (sel == 1) opc = {i_opc[$urandom_range(0, 7)], 1'($urandom_range(0, 1))};
            else               opc = 11'($urandom);
            r = ($urandom_range(0, 19) == 0);
            step(r, op, opc, r ? 4'b0000 : model(op, opc), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
